// File: rtl/uart_cmd_responder_if.sv
// Parallel-side byte bus between the UART top and the command responder.
// master = responder (drives transmit side), slave = UART top.
interface uart_cmd_responder_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_done;

    modport master (
        input  rx_data,
        input  rx_done,
        input  tx_done,
        output tx_data,
        output tx_en
    );

    modport slave (
        output rx_data,
        output rx_done,
        output tx_done,
        input  tx_data,
        input  tx_en
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// Parses 4-byte request frames (HDR, CMD, ARG, CHK) from the UART receive side,
// executes register commands and returns a 3-byte response frame.
module uart_cmd_responder #(
    parameter logic [7:0]  RX_HDR      = 8'hA5,
    parameter logic [7:0]  TX_HDR      = 8'h5A,
    parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    uart_cmd_responder_if.master        uart,
    input  logic [7:0]                  reg_in_i,
    output logic [7:0]                  reg_out_o,
    output logic                        cmd_valid_o,
    output logic                        frame_err_o,
    output logic                        busy_o
);

    typedef enum logic [2:0] {
        ST_RX_HDR  = 3'd0,
        ST_RX_CMD  = 3'd1,
        ST_RX_ARG  = 3'd2,
        ST_RX_CHK  = 3'd3,
        ST_EXEC    = 3'd4,
        ST_TX_LOAD = 3'd5,
        ST_TX_WAIT = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic        rx_done_prev_q, tx_done_prev_q;
    logic [23:0] cnt_q, cnt_d;
    logic [7:0]  cmd_q, cmd_d, arg_q, arg_d, chk_q, chk_d;
    logic [7:0]  resp1_q, resp1_d, resp2_q, resp2_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  reg_out_q, reg_out_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        busy_q, busy_d;
    logic        rx_evt_s, tx_evt_s, timeout_s;

    function automatic logic frame_ok(input logic [7:0] cmd, input logic [7:0] arg,
                                      input logic [7:0] chk);
        return (chk == (cmd ^ arg)) &&
               ((cmd == 8'h01) || (cmd == 8'h02) || (cmd == 8'h03));
    endfunction

    // A level held high on either done flag yields exactly one event.
    assign rx_evt_s  = uart.rx_done & ~rx_done_prev_q;
    assign tx_evt_s  = uart.tx_done & ~tx_done_prev_q;
    assign timeout_s = (cnt_q == (TIMEOUT_CYC - 24'd1));

    // State register, edge-detect history and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= ST_RX_HDR;
            rx_done_prev_q <= 1'b0;
            tx_done_prev_q <= 1'b0;
            cnt_q          <= 24'd0;
            cmd_q          <= 8'h00;
            arg_q          <= 8'h00;
            chk_q          <= 8'h00;
            resp1_q        <= 8'h00;
            resp2_q        <= 8'h00;
            idx_q          <= 2'd0;
            tx_data_q      <= 8'h00;
            tx_en_q        <= 1'b0;
            reg_out_q      <= 8'h00;
            cmd_valid_q    <= 1'b0;
            frame_err_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rx_done_prev_q <= uart.rx_done;
            tx_done_prev_q <= uart.tx_done;
            cnt_q          <= cnt_d;
            cmd_q          <= cmd_d;
            arg_q          <= arg_d;
            chk_q          <= chk_d;
            resp1_q        <= resp1_d;
            resp2_q        <= resp2_d;
            idx_q          <= idx_d;
            tx_data_q      <= tx_data_d;
            tx_en_q        <= tx_en_d;
            reg_out_q      <= reg_out_d;
            cmd_valid_q    <= cmd_valid_d;
            frame_err_q    <= frame_err_d;
            busy_q         <= busy_d;
        end
    end

    // Next-state, frame parsing, command execution and transmit sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = 24'd0;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        chk_d       = chk_q;
        resp1_d     = resp1_q;
        resp2_d     = resp2_q;
        idx_d       = idx_q;
        tx_data_d   = tx_data_q;
        reg_out_d   = reg_out_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_RX_HDR: begin
                if (rx_evt_s && (uart.rx_data == RX_HDR)) begin
                    state_d = ST_RX_CMD;
                end else begin
                    state_d = ST_RX_HDR;
                end
            end
            // Timeout has priority: a byte landing on the expiry cycle is dropped.
            ST_RX_CMD: begin
                if (timeout_s) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_RX_HDR;
                end else if (rx_evt_s) begin
                    cmd_d   = uart.rx_data;
                    state_d = ST_RX_ARG;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            ST_RX_ARG: begin
                if (timeout_s) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_RX_HDR;
                end else if (rx_evt_s) begin
                    arg_d   = uart.rx_data;
                    state_d = ST_RX_CHK;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            ST_RX_CHK: begin
                if (timeout_s) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_RX_HDR;
                end else if (rx_evt_s) begin
                    chk_d   = uart.rx_data;
                    state_d = ST_EXEC;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            ST_EXEC: begin
                idx_d   = 2'd0;
                state_d = ST_TX_LOAD;
                if (!frame_ok(cmd_q, arg_q, chk_q)) begin
                    frame_err_d = 1'b1;
                    resp1_d     = 8'hEE;
                    resp2_d     = cmd_q;
                end else begin
                    cmd_valid_d = 1'b1;
                    resp1_d     = cmd_q;
                    case (cmd_q)
                        8'h01: begin
                            reg_out_d = arg_q;
                            resp2_d   = arg_q;
                        end
                        8'h02:   resp2_d = reg_in_i;
                        default: resp2_d = arg_q;
                    endcase
                end
            end
            ST_TX_LOAD: begin
                state_d = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (tx_evt_s) begin
                    if (idx_q == 2'd2) begin
                        state_d = ST_RX_HDR;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_TX_LOAD;
                    end
                end else begin
                    state_d = ST_TX_WAIT;
                end
            end
            default: begin
                state_d = ST_RX_HDR;
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        tx_en_d = (state_d == ST_TX_LOAD);
        busy_d  = (state_d == ST_EXEC) || (state_d == ST_TX_LOAD) || (state_d == ST_TX_WAIT);
        if (state_d == ST_TX_LOAD) begin
            case (idx_d)
                2'd0:    tx_data_d = TX_HDR;
                2'd1:    tx_data_d = resp1_d;
                default: tx_data_d = resp2_d;
            endcase
        end else begin
            tx_data_d = tx_data_q;
        end
    end

    assign uart.tx_data = tx_data_q;
    assign uart.tx_en   = tx_en_q;
    assign reg_out_o    = reg_out_q;
    assign cmd_valid_o  = cmd_valid_q;
    assign frame_err_o  = frame_err_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: expected response bytes are queued
// per request frame and compared against each TxEn strobe.
module tb_uart_cmd_responder;

    logic       clk;
    logic       rst_n;
    logic [7:0] reg_in;
    logic [7:0] reg_out;
    logic       cmd_valid;
    logic       frame_err;
    logic       busy;

    uart_cmd_responder_if uart_if();

    uart_cmd_responder #(
        .RX_HDR      (8'hA5),
        .TX_HDR      (8'h5A),
        .TIMEOUT_CYC (24'd100)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .uart        (uart_if),
        .reg_in_i    (reg_in),
        .reg_out_o   (reg_out),
        .cmd_valid_o (cmd_valid),
        .frame_err_o (frame_err),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb[$];
    int         txen_cnt = 0;
    int         cv_cnt   = 0;
    int         fe_cnt   = 0;
    int         tx_done_len = 1;
    int         rx_hold     = 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transmit monitor plus TxDone model; also counts one-cycle status pulses.
    initial begin : tx_model
        int  dly;
        int  hold;
        logic pend;
        dly  = 0;
        hold = 0;
        pend = 1'b0;
        uart_if.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dly  = 0;
                hold = 0;
                pend = 1'b0;
                uart_if.tx_done = 1'b0;
            end else begin
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) uart_if.tx_done = 1'b0;
                end
                if (dly > 0) begin
                    dly--;
                    if (dly == 0) begin
                        uart_if.tx_done = 1'b1;
                        hold = tx_done_len;
                        pend = 1'b0;
                    end
                end
                if (uart_if.tx_en) begin
                    txen_cnt++;
                    check_eq("tx_en_before_done", 32'(pend), 32'd0);
                    pend = 1'b1;
                    if (sb.size() == 0) begin
                        check_eq("tx_unexpected", 32'(uart_if.tx_data), 32'hFFFF_FFFF);
                    end else begin
                        check_eq("tx_data", 32'(uart_if.tx_data), 32'(sb.pop_front()));
                    end
                    dly = tx_done_len + 3;
                end
                if (cmd_valid) cv_cnt++;
                if (frame_err) fe_cnt++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        uart_if.rx_data = b;
        uart_if.rx_done = 1'b1;
        repeat (rx_hold) @(negedge clk);
        uart_if.rx_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(k);
    endtask

    task automatic expect_resp(input logic [7:0] b1, input logic [7:0] b2);
        sb.push_back(8'h5A);
        sb.push_back(b1);
        sb.push_back(b2);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (4) @(negedge clk);
        while ((busy || sb.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_wait_bound", 32'(n < 2000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Runs one frame and checks pulse and strobe counts produced by it.
    task automatic run_frame(input string tag, input logic [7:0] c, input logic [7:0] a,
                             input logic [7:0] k, input int exp_cv, input int exp_fe);
        int tx0, cv0, fe0;
        tx0 = txen_cnt;
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_frame(c, a, k);
        wait_idle();
        check_eq({tag, "_txen"}, 32'(txen_cnt - tx0), 32'd3);
        check_eq({tag, "_cmd_valid"}, 32'(cv_cnt - cv0), 32'(exp_cv));
        check_eq({tag, "_frame_err"}, 32'(fe_cnt - fe0), 32'(exp_fe));
    endtask

    initial begin : stim
        int tx0, fe0, n;
        rst_n           = 1'b0;
        reg_in          = 8'h00;
        uart_if.rx_data = 8'h00;
        uart_if.rx_done = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx_en", 32'(uart_if.tx_en), 32'd0);
        check_eq("rst_tx_data", 32'(uart_if.tx_data), 32'h00);
        check_eq("rst_reg_out", 32'(reg_out), 32'h00);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_pulses", 32'({cmd_valid, frame_err}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        expect_resp(8'h01, 8'h3C);
        run_frame("write", 8'h01, 8'h3C, 8'h3D, 1, 0);
        check_eq("write_reg_out", 32'(reg_out), 32'h3C);

        reg_in = 8'h96;
        expect_resp(8'h02, 8'h96);
        run_frame("read", 8'h02, 8'h00, 8'h02, 1, 0);
        check_eq("read_reg_out", 32'(reg_out), 32'h3C);

        expect_resp(8'hEE, 8'h03);
        run_frame("badchk", 8'h03, 8'h11, 8'h00, 0, 1);
        expect_resp(8'hEE, 8'h07);
        run_frame("badcmd", 8'h07, 8'h00, 8'h07, 0, 1);
        check_eq("err_reg_out", 32'(reg_out), 32'h3C);

        send_byte(8'h00);
        send_byte(8'hFF);
        expect_resp(8'h03, 8'h55);
        run_frame("sync", 8'h03, 8'h55, 8'h56, 1, 0);

        tx0 = txen_cnt;
        fe0 = fe_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (150) @(negedge clk);
        check_eq("timeout_frame_err", 32'(fe_cnt - fe0), 32'd1);
        check_eq("timeout_no_txen", 32'(txen_cnt - tx0), 32'd0);
        check_eq("timeout_busy", 32'(busy), 32'd0);
        expect_resp(8'h01, 8'h0F);
        run_frame("after_timeout", 8'h01, 8'h0F, 8'h0E, 1, 0);
        check_eq("after_timeout_reg_out", 32'(reg_out), 32'h0F);

        rx_hold     = 10;
        tx_done_len = 5;
        expect_resp(8'h03, 8'h77);
        run_frame("held_levels", 8'h03, 8'h77, 8'h74, 1, 0);

        // A header byte arriving mid-response must not open a frame.
        tx0 = txen_cnt;
        expect_resp(8'h01, 8'hAA);
        send_frame(8'h01, 8'hAA, 8'hAB);
        repeat (4) @(negedge clk);
        check_eq("inject_busy", 32'(busy), 32'd1);
        send_byte(8'hA5);
        wait_idle();
        check_eq("inject_txen", 32'(txen_cnt - tx0), 32'd3);
        tx0 = txen_cnt;
        fe0 = fe_cnt;
        send_byte(8'h03);
        send_byte(8'h12);
        send_byte(8'h11);
        repeat (20) @(negedge clk);
        check_eq("inject_dropped_txen", 32'(txen_cnt - tx0), 32'd0);
        check_eq("inject_dropped_err", 32'(fe_cnt - fe0), 32'd0);

        rx_hold     = 1;
        tx_done_len = 1;
        tx0 = txen_cnt;
        expect_resp(8'h03, 8'h21);
        send_frame(8'h03, 8'h21, 8'h22);
        n = 0;
        while ((txen_cnt - tx0) < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_reset_reach", 32'(txen_cnt - tx0), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_reset_tx_en", 32'(uart_if.tx_en), 32'd0);
        check_eq("mid_reset_busy", 32'(busy), 32'd0);
        check_eq("mid_reset_reg_out", 32'(reg_out), 32'h00);
        check_eq("mid_reset_tx_data", 32'(uart_if.tx_data), 32'h00);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        expect_resp(8'h01, 8'h5C);
        run_frame("post_reset", 8'h01, 8'h5C, 8'h5D, 1, 0);
        check_eq("post_reset_reg_out", 32'(reg_out), 32'h5C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
